dl_core_p: RTL and testbench

//  Parametrised successor of the DL 8-bit-instruction micro core: width-generic datapath, real carry

---
 rtl/dl_core_pkg.sv | 52 +++++
 rtl/dl_core_alu.sv | 76 +++++++
 rtl/dl_core_p.sv | 161 ++++++++++++++++
 tb/tb_dl_core_p.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_core_pkg.sv
// ============================================================================
//  Module   : dl_core_pkg
//  Purpose  : Shared opcodes, register indices and FSM state type for the
//             DL parametrised micro core (dl_core_p / dl_core_alu).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dl_core_pkg;

   // Opcode field is ir[7:3]; grouped opcodes are given as their fixed prefix
   localparam logic [1:0] OP_MOV  = 2'b00;      // 00ddd : rd <= rs
   localparam logic [4:0] OP_ADD  = 5'b01000;
   localparam logic [4:0] OP_OR   = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_XOR  = 5'b01011;
   localparam logic [4:0] OP_INC  = 5'b01100;
   localparam logic [4:0] OP_NOT  = 5'b01101;
   localparam logic [4:0] OP_SHR  = 5'b01110;
   localparam logic [4:0] OP_SHL  = 5'b01111;
   localparam logic [3:0] OP_JNC  = 4'b1000;    // 1000i
   localparam logic [3:0] OP_JMP  = 4'b1001;    // 1001i
   localparam logic [3:0] OP_SET  = 4'b1010;    // 1010i
   localparam logic [3:0] OP_NOP  = 4'b1011;    // 1011x
   localparam logic [4:0] OP_HALT = 5'b11000;   // other 11xxx are NOPs

   // Register indices with special meaning
   localparam logic [2:0] R_ACC = 3'd0;
   localparam logic [2:0] R_IN  = 3'd5;
   localparam logic [2:0] R_OUT = 3'd6;
   localparam logic [2:0] R_PC  = 3'd7;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Destination register of an instruction: MOV names it, unary ops write
   // back to their source, everything else targets the accumulator.
   function automatic logic [2:0] dest_of(input logic [7:0] ir);
      if (ir[7:6] == OP_MOV)
         return ir[5:3];
      else if (ir[7:5] == 3'b011)
         return ir[2:0];
      else
         return R_ACC;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dl_core_alu.sv
// ============================================================================
//  Module   : dl_core_alu
//  Purpose  : Combinational datapath of the DL core. a = r0, b = selected
//             operand (source register, or imm4 for SET). Produces result,
//             carry out and a write-enable for the destination register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dl_core_alu
   import dl_core_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [4:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              c_in,
   output logic [DATA_W-1:0] result,
   output logic              c_out,
   output logic              we
);

   logic [DATA_W:0] w_sum;

   // Decode the opcode into a result; carry is preserved unless the op defines it
   always_comb begin
      result = '0;
      c_out  = c_in;
      we     = 1'b0;
      w_sum  = '0;
      if (op[4:3] == OP_MOV) begin
         result = b;
         we     = 1'b1;
      end else begin
         case (op)
            OP_ADD: begin
               w_sum  = {1'b0, a} + {1'b0, b};
               result = w_sum[DATA_W-1:0];
               c_out  = w_sum[DATA_W];
               we     = 1'b1;
            end
            OP_OR:  begin result = a | b; we = 1'b1; end
            OP_AND: begin result = a & b; we = 1'b1; end
            OP_XOR: begin result = a ^ b; we = 1'b1; end
            OP_INC: begin
               w_sum  = {1'b0, b} + {{DATA_W{1'b0}}, 1'b1};
               result = w_sum[DATA_W-1:0];
               c_out  = w_sum[DATA_W];
               we     = 1'b1;
            end
            OP_NOT: begin result = ~b; we = 1'b1; end
            OP_SHR: begin
               result = b >> 1;
               c_out  = b[0];
               we     = 1'b1;
            end
            OP_SHL: begin
               result = b << 1;
               c_out  = b[DATA_W-1];
               we     = 1'b1;
            end
            default: begin
               // SET passes the immediate through; jumps, NOP and HALT write nothing
               if (op[4:1] == OP_SET) begin
                  result = b;
                  we     = 1'b1;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/dl_core_p.sv
// ============================================================================
//  Module   : dl_core_p
//  Purpose  : Parametrised DL micro core. FETCH/EXEC state machine with a
//             req/ack instruction-fetch handshake, r0..r6 register file
//             (r5 = btn sample, r6 = led), r7 aliases the program counter.
//  Config   : DL_CORE_TRACE_EN adds retire / retire_pc / retire_ir outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dl_core_p
   import dl_core_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] btn,
   output logic [DATA_W-1:0] led,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [7:0]        imem_data,
   output logic              halted
`ifdef DL_CORE_TRACE_EN
   ,
   output logic              retire,
   output logic [PC_W-1:0]   retire_pc,
   output logic [7:0]        retire_ir
`endif
);

   state_t            r_state;
   logic [7:0]        r_ir;
   logic [PC_W-1:0]   r_pc;
   logic              r_c;
   logic              r_req;
   logic              r_halted;
   logic [DATA_W-1:0] r_rf [0:6];

   logic [4:0]        w_op;
   logic [2:0]        w_sss;
   logic [3:0]        w_imm;
   logic [2:0]        w_dest;
   logic [DATA_W-1:0] w_rd [0:7];
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_c;
   logic              w_alu_we;
   logic              w_jump;
   logic [PC_W-1:0]   w_jump_pc;
   logic [PC_W-1:0]   w_next_pc;

   assign w_op   = r_ir[7:3];
   assign w_sss  = r_ir[2:0];
   assign w_imm  = r_ir[3:0];          // {op[0], sss}
   assign w_dest = dest_of(r_ir);

   // Read view of r0..r7; r7 is the pc resized to the datapath width
   always_comb begin
      for (int i = 0; i < 7; i++)
         w_rd[i] = r_rf[i];
      w_rd[7] = DATA_W'(r_pc);
   end

   assign w_b = (w_op[4:1] == OP_SET) ? DATA_W'(w_imm) : w_rd[w_sss];

   dl_core_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op     (w_op),
      .a      (w_rd[R_ACC]),
      .b      (w_b),
      .c_in   (r_c),
      .result (w_alu_res),
      .c_out  (w_alu_c),
      .we     (w_alu_we)
   );

   // Jumps stay within the current 16-word page
   assign w_jump    = (w_op[4:1] == OP_JMP) || ((w_op[4:1] == OP_JNC) && !r_c);
   assign w_jump_pc = (r_pc & ~PC_W'(4'hF)) | PC_W'(w_imm);

   // Next pc: jump target, explicit r7 load, or sequential increment
   always_comb begin
      if (w_jump)
         w_next_pc = w_jump_pc;
      else if (w_alu_we && (w_dest == R_PC))
         w_next_pc = PC_W'(w_alu_res);
      else
         w_next_pc = r_pc + PC_W'(1);
   end

   // Core state machine: fetch handshake, execute/commit, halt
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_FETCH;
         r_req    <= 1'b0;
         r_halted <= 1'b0;
         r_ir     <= '0;
         r_pc     <= '0;
         r_c      <= 1'b0;
         for (int i = 0; i < 7; i++)
            r_rf[i] <= '0;
      end else begin
         // Input port is sampled every cycle, whatever the core is doing
         r_rf[R_IN] <= btn;
         case (r_state)
            ST_FETCH: begin
               // First cycle after reset raises the request; afterwards wait for ack
               if (!r_req) begin
                  r_req <= 1'b1;
               end else if (imem_ack) begin
                  r_ir    <= imem_data;
                  r_req   <= 1'b0;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_c  <= w_alu_c;
               r_pc <= w_next_pc;
               for (int i = 0; i < 7; i++) begin
                  if (w_alu_we && (w_dest == 3'(i)) && (3'(i) != R_IN))
                     r_rf[i] <= w_alu_res;
               end
               if (w_op == OP_HALT) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state  <= ST_FETCH;
                  r_req    <= 1'b1;
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_FETCH;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign led       = r_rf[R_OUT];
   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign halted    = r_halted;

`ifdef DL_CORE_TRACE_EN
   logic w_retire;
   assign w_retire  = (r_state == ST_EXEC);
   assign retire    = w_retire;
   assign retire_pc = w_retire ? r_pc : '0;
   assign retire_ir = w_retire ? r_ir : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dl_core_p.sv
// ============================================================================
//  Module   : tb_dl_core_p
//  Purpose  : Scoreboard bench for dl_core_p (DATA_W=4, PC_W=6). An
//             instruction-level reference model predicts the fetch address
//             and led value seen at every fetch handshake, plus halt events.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dl_core_p;

   localparam int DW = 4;
   localparam int PW = 6;
   localparam int M  = 16;   // 2**DW
   localparam int PM = 64;   // 2**PW

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] btn = '0;
   logic [DW-1:0] led;
   logic          imem_req;
   logic [PW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [7:0]    imem_data = 8'h00;
   logic          halted;

   dl_core_p #(.DATA_W(DW), .PC_W(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn),
      .led       (led),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   typedef struct { bit halt; int pc; int led; } exp_t;

   exp_t       q[$];
   logic [7:0] prog [0:63];
   int         checks = 0, failures = 0;
   int         m_r [0:7];
   int         m_pc = 0, m_c = 0;
   int         fixed_wait = 0;
   bit         btn_rand = 0;
   bit         active = 0;
   bit         hs_flag = 0;
   bit         halted_seen = 0;
   int         hs_count = 0;
   int         cyc = 0, last_hs_cyc = 0;
   bit         has_prev = 0, prev_req = 0, prev_hs = 0;
   int         prev_addr = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: one whole instruction per call, plain integer arithmetic
   task automatic model_exec(input logic [7:0] ins, input int bv);
      int op, s, imm, a, acc, v, d, npc;
      bit wr, stop;
      op = int'(ins[7:3]); s = int'(ins[2:0]); imm = int'(ins[3:0]);
      npc = (m_pc + 1) % PM; wr = 0; stop = 0; v = 0; d = 0;
      acc = m_r[0];
      if (s == 7) a = m_pc % M;
      else if (s == 5) a = bv;
      else a = m_r[s];
      if (op < 8) begin wr = 1; d = op; v = a; end
      else case (op)
         8:  begin v = acc + a; m_c = (v >= M) ? 1 : 0; v = v % M; wr = 1; end
         9:  begin v = acc | a; wr = 1; end
         10: begin v = acc & a; wr = 1; end
         11: begin v = acc ^ a; wr = 1; end
         12: begin v = a + 1; m_c = (v >= M) ? 1 : 0; v = v % M; wr = 1; d = s; end
         13: begin v = M - 1 - a; wr = 1; d = s; end
         14: begin m_c = a % 2; v = a / 2; wr = 1; d = s; end
         15: begin m_c = (a >= M / 2) ? 1 : 0; v = (a * 2) % M; wr = 1; d = s; end
         16, 17: if (m_c == 0) npc = (m_pc / 16) * 16 + imm;
         18, 19: npc = (m_pc / 16) * 16 + imm;
         20, 21: begin v = imm % M; wr = 1; end
         24: stop = 1;
         default: ;
      endcase
      if (wr) begin
         if (d == 7) npc = v % PM;
         else if (d != 5) m_r[d] = v;
      end
      if (stop) q.push_back('{1'b1, 0, 0});
      else begin
         m_pc = npc;
         q.push_back('{1'b0, m_pc, m_r[6]});
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Stimulus side: every accepted fetch advances the model and queues the next expectation
   always @(negedge clk) begin
      if (active && reset && imem_req && imem_ack) begin
         model_exec(prog[m_pc], int'(btn));
         hs_count++;
         hs_flag = 1;
      end
   end

   // Monitor: compare DUT at each fetch handshake and at halt entry
   always @(negedge clk) begin : monitor
      exp_t e;
      if (active && reset) begin
         if (imem_req && prev_req && !prev_hs)
            check("addr_stable", int'(imem_addr), prev_addr);
         if (imem_req && imem_ack) begin
            if (q.size() == 0) check("fetch_expected", 0, 1);
            else begin
               e = q.pop_front();
               check("fetch_not_halt", 0, int'(e.halt));
               if (!e.halt) begin
                  check("fetch_addr", int'(imem_addr), e.pc);
                  check("fetch_led", int'(led), e.led);
               end
            end
            if (fixed_wait >= 0 && has_prev)
               check("cycles_per_instr", cyc - last_hs_cyc, 2 + fixed_wait);
            has_prev = 1;
            last_hs_cyc = cyc;
         end
         if (halted && !halted_seen) begin
            halted_seen = 1;
            if (q.size() == 0) check("halt_expected", 0, 1);
            else begin
               e = q.pop_front();
               check("halt_expected", int'(e.halt), 1);
            end
         end
         if (halted) check("req_low_halted", int'(imem_req), 0);
         prev_req  = imem_req;
         prev_hs   = imem_req && imem_ack;
         prev_addr = int'(imem_addr);
      end
   end

   // Instruction memory responder with wait states; junk ack/data while no request
   initial begin : driver
      int wcnt, wtarget;
      bit wsel;
      wcnt = 0; wtarget = 0; wsel = 0;
      forever begin
         @(posedge clk); #1;
         if (hs_flag) begin
            hs_flag = 0;
            if (btn_rand) btn = DW'($urandom);
         end
         if (!reset) begin
            imem_ack = 1'b0; wsel = 0; wcnt = 0;
         end else if (imem_req) begin
            if (!wsel) begin
               wsel = 1; wcnt = 0;
               wtarget = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(3, 0));
            end
            if (wcnt < wtarget) begin
               imem_ack = 1'b0; imem_data = 8'($urandom); wcnt++;
            end else begin
               imem_ack = 1'b1; imem_data = prog[imem_addr];
            end
         end else begin
            wsel = 0;
            imem_ack  = 1'($urandom);
            imem_data = 8'($urandom);
         end
      end
   end

   task automatic do_reset();
      active = 0; reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_led", int'(led), 0);
      check("rst_req", int'(imem_req), 0);
      check("rst_halted", int'(halted), 0);
      check("rst_addr", int'(imem_addr), 0);
      q.delete();
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_pc = 0; m_c = 0; hs_count = 0; halted_seen = 0; hs_flag = 0;
      has_prev = 0; prev_req = 0; prev_hs = 0;
      q.push_back('{1'b0, 0, 0});
      @(negedge clk);
      reset = 1'b1; active = 1;
   endtask

   task automatic run_phase(input string name, input int max_hs, input bit expect_halt);
      int left;
      left = 1500;
      while (!halted_seen && hs_count < max_hs && left > 0) begin
         @(posedge clk); left--;
      end
      check({name, "_no_timeout"}, int'(left > 0), 1);
      if (expect_halt) begin
         check({name, "_halted"}, int'(halted_seen), 1);
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic reset_mid_exec();
      int n;
      n = 0;
      @(negedge clk);
      while (!(imem_req && imem_ack) && n < 60) begin @(negedge clk); n++; end
      check("midexec_hs_seen", int'(n < 60), 1);
      @(posedge clk); #2;
      active = 0; reset = 1'b0;
      #1;
      check("midexec_led", int'(led), 0);
      check("midexec_req", int'(imem_req), 0);
      check("midexec_halted", int'(halted), 0);
      check("midexec_addr", int'(imem_addr), 0);
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 64; i++) prog[i] = v;
   endtask

   task automatic load_add_prog();
      fill(8'hC0);
      prog[0] = 8'hA9;  // SET 9
      prog[1] = 8'h08;  // MOV r1,r0
      prog[2] = 8'h41;  // ADD r1
      prog[3] = 8'h80;  // JNC 0
      prog[4] = 8'h30;  // MOV r6,r0
      prog[5] = 8'hC0;  // HALT
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int n;
      btn_rand = 1;
      btn = DW'($urandom);

      // Arithmetic / carry / JNC not taken, zero wait states
      load_add_prog(); fixed_wait = 0;
      do_reset();
      run_phase("add0w", 100, 1);
      check("add0w_led", int'(led), 2);

      // Same program with three wait states per fetch
      fixed_wait = 3;
      do_reset();
      run_phase("add3w", 100, 1);
      check("add3w_led", int'(led), 2);

      // Shifts and carry, observed through led and JNC
      fill(8'hC0); fixed_wait = -1;
      prog[0] = 8'hA9;  prog[1] = 8'h70;  prog[2] = 8'h30;  prog[3] = 8'h85;
      prog[4] = 8'h78;  prog[5] = 8'h30;  prog[6] = 8'h89;
      prog[9] = 8'h78;  prog[10] = 8'h30; prog[11] = 8'h80; prog[12] = 8'hC0;
      do_reset();
      run_phase("shift", 100, 1);
      check("shift_led", int'(led), 0);

      // Page-local jumps and r7 loads
      fill(8'hC0);
      prog[0] = 8'hAF;  prog[1] = 8'h38;  prog[15] = 8'hB8; prog[16] = 8'h9F;
      prog[31] = 8'h93; prog[19] = 8'hA5; prog[20] = 8'h38; prog[5] = 8'h37;
      prog[6] = 8'hC0;
      do_reset();
      run_phase("jump", 100, 1);
      check("jump_led", int'(led), 5);

      // pc wrap-around across the full address space
      fill(8'hB8); fixed_wait = 0;
      do_reset();
      run_phase("wrap", 66, 0);
      reset_mid_exec();

      // Input port sampling and r5 write discard
      fill(8'hC0); fixed_wait = -1; btn_rand = 0; btn = 4'hA;
      prog[0] = 8'h35; prog[1] = 8'h28; prog[2] = 8'h35; prog[3] = 8'hC0;
      do_reset();
      n = 0;
      while (!(imem_req && imem_ack) && n < 60) begin @(negedge clk); n++; end
      @(negedge clk);
      check("btn_led_exec_cycle", int'(led), 0);
      @(negedge clk);
      check("btn_led_after", int'(led), 10);
      run_phase("btn", 100, 1);
      check("btn_led_final", int'(led), 10);
      btn_rand = 1;

      // Randomized programs with random wait states and button values
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
         fixed_wait = (it % 3 == 0) ? int'($urandom_range(3, 0)) : -1;
         do_reset();
         run_phase("rand", 50, 0);
         if (!halted_seen) reset_mid_exec();
         else repeat (4) @(negedge clk);
      end

      active = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
